// File: rtl/control_param_n_if.sv
// Sequencer bus: job control, bank read data, steered lanes and memory/MAC controls.
interface control_param_n_if #(
  parameter int unsigned DATA_WIDTH           = 16,
  parameter int unsigned IFMAP_PAR            = 4,
  parameter int unsigned NUM_GROUPS           = 2,
  parameter int unsigned COUNT_SLOAD_BITWIDTH = 4
);
  localparam int unsigned INPUT_NUM_MEM = IFMAP_PAR * NUM_GROUPS;
  localparam int unsigned GROUP_W       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic                                  enable;
  logic                                  stall;
  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]   in_feature_q_a_all;
  logic [DATA_WIDTH*INPUT_NUM_MEM-1:0]   in_feature_q_b_all;
  logic [DATA_WIDTH*IFMAP_PAR-1:0]       in_feature_q_a_mux_all;
  logic [DATA_WIDTH*IFMAP_PAR-1:0]       in_feature_q_b_mux_all;
  logic                                  in_feature_rden_a;
  logic                                  in_feature_rden_b;
  logic                                  weight_rden_a;
  logic                                  weight_rden_b;
  logic                                  in_feature_wren_a;
  logic                                  in_feature_wren_b;
  logic                                  weight_wren_a;
  logic                                  weight_wren_b;
  logic                                  enable_addrger;
  logic                                  enable_weightaddrger;
  logic                                  enable_mult;
  logic                                  clear_mult;
  logic                                  accum_sload;
  logic [COUNT_SLOAD_BITWIDTH-1:0]       count_sload;
  logic [GROUP_W-1:0]                    group;
  logic                                  start;
  logic                                  conv_done;
  logic                                  busy;

  // Scheduler / memory side.
  modport master (
    output enable, stall, in_feature_q_a_all, in_feature_q_b_all,
    input  in_feature_q_a_mux_all, in_feature_q_b_mux_all,
           in_feature_rden_a, in_feature_rden_b, weight_rden_a, weight_rden_b,
           in_feature_wren_a, in_feature_wren_b, weight_wren_a, weight_wren_b,
           enable_addrger, enable_weightaddrger, enable_mult, clear_mult,
           accum_sload, count_sload, group, start, conv_done, busy
  );

  // Sequencer side.
  modport slave (
    input  enable, stall, in_feature_q_a_all, in_feature_q_b_all,
    output in_feature_q_a_mux_all, in_feature_q_b_mux_all,
           in_feature_rden_a, in_feature_rden_b, weight_rden_a, weight_rden_b,
           in_feature_wren_a, in_feature_wren_b, weight_wren_a, weight_wren_b,
           enable_addrger, enable_weightaddrger, enable_mult, clear_mult,
           accum_sload, count_sload, group, start, conv_done, busy
  );
endinterface

// File: rtl/control_param_n.sv
// Convolution-engine sequencer: one output-feature-map pass per job with
// fill/run/drain phasing, stall, abort and channel-group lane steering.
module control_param_n #(
  parameter int unsigned DATA_WIDTH                = 16,
  parameter int unsigned IFMAP_PAR                 = 4,
  parameter int unsigned NUM_GROUPS                = 2,
  parameter int unsigned NUM_ONE_PIXEL_CYCLE       = 13,
  parameter int unsigned NUM_ONE_PIXEL_CYCLE_INTER = 13,
  parameter int unsigned PIPE_DELAY                = 4,
  parameter int unsigned OUT_FEATURE_WIDTH         = 32,
  parameter int unsigned OUT_FEATURE_HEIGHT        = 32,
  parameter int unsigned NUM_ONEMULT               = 1,
  parameter int unsigned COUNT_SLOAD_BITWIDTH      = 4,
  parameter int unsigned COUNT_CONV_DONE_BITWIDTH  = 12
) (
  input  logic               clock,
  input  logic               reset,
  control_param_n_if.slave   bus
);

  localparam int unsigned INPUT_NUM_MEM = IFMAP_PAR * NUM_GROUPS;
  localparam int unsigned TOTAL         = OUT_FEATURE_WIDTH * OUT_FEATURE_HEIGHT * NUM_ONEMULT;
  localparam int unsigned GROUP_W       = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
  localparam int unsigned BANK_W        = (INPUT_NUM_MEM > 1) ? $clog2(INPUT_NUM_MEM) : 1;
  localparam int unsigned PHASE_W       = $clog2(PIPE_DELAY + 1);
  localparam int unsigned CS_W          = COUNT_SLOAD_BITWIDTH;
  localparam int unsigned PIX_W         = COUNT_CONV_DONE_BITWIDTH;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FILL  = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [CS_W-1:0]    cs_q, cs_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [PIX_W-1:0]   pix_inc;
  logic [GROUP_W-1:0] grp_q, grp_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               clear_q, clear_d;
  logic               rden_q, rden_d;
  logic               wren_q;
  logic               active;

  assign pix_inc = pix_q + PIX_W'(1);
  assign active  = (state_q == S_FILL) || (state_q == S_RUN) || (state_q == S_DRAIN);

  // State and counter registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      cs_q    <= '0;
      pix_q   <= '0;
      grp_q   <= '0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      clear_q <= 1'b0;
      rden_q  <= 1'b0;
      wren_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      cs_q    <= cs_d;
      pix_q   <= pix_d;
      grp_q   <= grp_d;
      start_q <= start_d;
      done_q  <= done_d;
      clear_q <= clear_d;
      rden_q  <= rden_d;
      wren_q  <= 1'b0;
    end
  end

  // Next-state and counter sequencing; abort and stall handled per phase.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    cs_d    = cs_q;
    pix_d   = pix_q;
    grp_d   = grp_q;
    start_d = start_q;
    done_d  = done_q;
    clear_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        start_d = 1'b0;
        done_d  = 1'b0;
        if (bus.enable) begin
          state_d = S_FILL;
          clear_d = 1'b1;
          phase_d = '0;
          cs_d    = '0;
          pix_d   = '0;
          grp_d   = '0;
        end
      end
      S_FILL, S_DRAIN: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (!bus.stall) begin
          if (phase_q == PHASE_W'(PIPE_DELAY - 1)) begin
            phase_d = '0;
            if (state_q == S_FILL) begin
              state_d = S_RUN;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else begin
            phase_d = phase_q + PHASE_W'(1);
          end
        end
      end
      S_RUN: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
        end else if (!bus.stall) begin
          if (cs_q == CS_W'(NUM_ONE_PIXEL_CYCLE - 1)) begin
            cs_d    = '0;
            pix_d   = pix_inc;
            start_d = 1'b1;
            grp_d   = (grp_q == GROUP_W'(NUM_GROUPS - 1)) ? '0 : grp_q + GROUP_W'(1);
            if (pix_inc == PIX_W'(TOTAL)) begin
              state_d = S_DRAIN;
            end
          end else begin
            cs_d = cs_q + CS_W'(1);
          end
        end
      end
      S_DONE: begin
        done_d = 1'b1;
        if (!bus.enable) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Any return to IDLE (abort or acknowledge) wipes the job context.
    if (state_q != S_IDLE && state_d == S_IDLE) begin
      phase_d = '0;
      cs_d    = '0;
      pix_d   = '0;
      grp_d   = '0;
      start_d = 1'b0;
      done_d  = 1'b0;
    end

    rden_d = (state_d == S_FILL) || (state_d == S_RUN) || (state_d == S_DRAIN);
  end

  // Unpack bank read data for group-based indexing.
  logic [DATA_WIDTH-1:0] bank_a [INPUT_NUM_MEM];
  logic [DATA_WIDTH-1:0] bank_b [INPUT_NUM_MEM];

  for (genvar k = 0; k < INPUT_NUM_MEM; k++) begin : g_bank
    assign bank_a[k] = bus.in_feature_q_a_all[k*DATA_WIDTH +: DATA_WIDTH];
    assign bank_b[k] = bus.in_feature_q_b_all[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // Lane steering: lane i reads bank group*IFMAP_PAR+i, zeroed past the valid taps.
  logic [DATA_WIDTH*IFMAP_PAR-1:0] mux_a;
  logic [DATA_WIDTH*IFMAP_PAR-1:0] mux_b;
  logic                            tap_a_ok;
  logic                            tap_b_ok;
  logic [BANK_W-1:0]               sel;

  always_comb begin
    mux_a    = '0;
    mux_b    = '0;
    sel      = '0;
    tap_a_ok = (32'(cs_q) < NUM_ONE_PIXEL_CYCLE_INTER);
    tap_b_ok = ((32'(cs_q) + 32'd1) < NUM_ONE_PIXEL_CYCLE_INTER);
    for (int unsigned i = 0; i < IFMAP_PAR; i++) begin
      sel = BANK_W'(32'(grp_q) * IFMAP_PAR + i);
      mux_a[i*DATA_WIDTH +: DATA_WIDTH] = tap_a_ok ? bank_a[sel] : '0;
      mux_b[i*DATA_WIDTH +: DATA_WIDTH] = tap_b_ok ? bank_b[sel] : '0;
    end
  end

  assign bus.in_feature_q_a_mux_all = mux_a;
  assign bus.in_feature_q_b_mux_all = mux_b;

  assign bus.in_feature_rden_a    = rden_q;
  assign bus.in_feature_rden_b    = rden_q;
  assign bus.weight_rden_a        = rden_q;
  assign bus.weight_rden_b        = rden_q;
  assign bus.in_feature_wren_a    = wren_q;
  assign bus.in_feature_wren_b    = wren_q;
  assign bus.weight_wren_a        = wren_q;
  assign bus.weight_wren_b        = wren_q;

  // Advance strobes drop in the same cycle a stall is raised.
  assign bus.enable_addrger       = active && !bus.stall;
  assign bus.enable_weightaddrger = active && !bus.stall;
  assign bus.enable_mult          = active && !bus.stall;

  assign bus.clear_mult  = clear_q;
  assign bus.accum_sload = (state_q == S_RUN) && (cs_q == '0);
  assign bus.count_sload = cs_q;
  assign bus.group       = grp_q;
  assign bus.start       = start_q;
  assign bus.conv_done   = done_q;
  assign bus.busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_control_param_n.sv
// Directed bench for control_param_n with a 2x2 output map, 4-cycle pixels,
// 3 valid taps, 2-cycle pipeline, 2 lanes and 2 channel groups.
module tb_control_param_n;

  localparam int unsigned DW  = 16;
  localparam int unsigned PAR = 2;
  localparam int unsigned NG  = 2;
  localparam int unsigned CSW = 4;

  logic clock;
  logic reset;

  int tests_run;
  int tests_failed;

  control_param_n_if #(
    .DATA_WIDTH(DW), .IFMAP_PAR(PAR), .NUM_GROUPS(NG), .COUNT_SLOAD_BITWIDTH(CSW)
  ) bus ();

  control_param_n #(
    .DATA_WIDTH(DW), .IFMAP_PAR(PAR), .NUM_GROUPS(NG),
    .NUM_ONE_PIXEL_CYCLE(4), .NUM_ONE_PIXEL_CYCLE_INTER(3), .PIPE_DELAY(2),
    .OUT_FEATURE_WIDTH(2), .OUT_FEATURE_HEIGHT(2), .NUM_ONEMULT(1),
    .COUNT_SLOAD_BITWIDTH(CSW), .COUNT_CONV_DONE_BITWIDTH(12)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Expected steered lanes: base 0x10 for port a, 0x20 for port b.
  function automatic logic [31:0] exp_lanes(input bit is_b, input int grp, input int cs);
    logic [15:0] base;
    logic [31:0] v;
    base = is_b ? 16'h0020 : 16'h0010;
    v = {base + 16'(grp*2 + 1), base + 16'(grp*2)};
    if (is_b ? (cs >= 2) : (cs >= 3)) v = 32'h0;
    return v;
  endfunction

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.stall  = 1'b0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %0b want 0", bus.busy); end
    tests_run++; if (bus.count_sload !== 4'd0) begin tests_failed++; $display("FAIL reset_count_sload: got %0d want 0", bus.count_sload); end
    tests_run++; if (bus.group !== 1'b0) begin tests_failed++; $display("FAIL reset_group: got %0d want 0", bus.group); end
    tests_run++; if (bus.start !== 1'b0 || bus.conv_done !== 1'b0) begin tests_failed++; $display("FAIL reset_start_done: got %0b/%0b want 0/0", bus.start, bus.conv_done); end
    tests_run++; if (bus.clear_mult !== 1'b0 || bus.accum_sload !== 1'b0) begin tests_failed++; $display("FAIL reset_clear_sload: got %0b/%0b want 0/0", bus.clear_mult, bus.accum_sload); end
    tests_run++; if (bus.in_feature_rden_a !== 1'b0 || bus.weight_rden_b !== 1'b0 || bus.in_feature_wren_a !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_en: got rden %0b/%0b wren %0b want 0", bus.in_feature_rden_a, bus.weight_rden_b, bus.in_feature_wren_a); end
    tests_run++; if (bus.enable_mult !== 1'b0 || bus.enable_addrger !== 1'b0) begin tests_failed++; $display("FAIL reset_enables: got %0b/%0b want 0/0", bus.enable_mult, bus.enable_addrger); end
    tests_run++; if (bus.in_feature_q_a_mux_all !== 32'h0011_0010) begin tests_failed++; $display("FAIL reset_mux_a: got %h want 00110010", bus.in_feature_q_a_mux_all); end
    tests_run++; if (bus.in_feature_q_b_mux_all !== 32'h0021_0020) begin tests_failed++; $display("FAIL reset_mux_b: got %h want 00210020", bus.in_feature_q_b_mux_all); end
  endtask

  task automatic test_basic();
    int start_e;
    int done_e;
    int acc_n;
    start_e = -1;
    done_e  = -1;
    acc_n   = 0;
    bus.enable = 1'b1;
    step();
    tests_run++; if (bus.busy !== 1'b1 || bus.clear_mult !== 1'b1) begin tests_failed++; $display("FAIL basic_fill_entry: got busy %0b clear %0b want 1/1", bus.busy, bus.clear_mult); end
    tests_run++; if (bus.in_feature_rden_a !== 1'b1 || bus.weight_rden_a !== 1'b1 || bus.enable_addrger !== 1'b1) begin tests_failed++; $display("FAIL basic_fill_en: got %0b/%0b/%0b want 1/1/1", bus.in_feature_rden_a, bus.weight_rden_a, bus.enable_addrger); end
    tests_run++; if (bus.accum_sload !== 1'b0) begin tests_failed++; $display("FAIL basic_fill_sload: got %0b want 0", bus.accum_sload); end
    for (int e = 1; e <= 21; e++) begin
      step();
      if (bus.accum_sload === 1'b1) acc_n++;
      if (start_e < 0 && bus.start === 1'b1) start_e = e;
      if (done_e < 0 && bus.conv_done === 1'b1) done_e = e;
      if (e == 1) begin
        tests_run++; if (bus.clear_mult !== 1'b0 || bus.accum_sload !== 1'b0) begin tests_failed++; $display("FAIL basic_edge1: got clear %0b sload %0b want 0/0", bus.clear_mult, bus.accum_sload); end
      end
      if (e == 2) begin
        tests_run++; if (bus.accum_sload !== 1'b1) begin tests_failed++; $display("FAIL basic_run_entry: got sload %0b want 1", bus.accum_sload); end
      end
    end
    tests_run++; if (acc_n !== 4) begin tests_failed++; $display("FAIL basic_accum_count: got %0d want 4", acc_n); end
    tests_run++; if (start_e !== 6) begin tests_failed++; $display("FAIL basic_start_edge: got %0d want 6", start_e); end
    tests_run++; if (done_e !== 20) begin tests_failed++; $display("FAIL basic_done_edge: got %0d want 20", done_e); end
    tests_run++; if (bus.conv_done !== 1'b1 || bus.busy !== 1'b1 || bus.in_feature_rden_a !== 1'b0) begin tests_failed++; $display("FAIL basic_done_hold: got done %0b busy %0b rden %0b want 1/1/0", bus.conv_done, bus.busy, bus.in_feature_rden_a); end
    bus.enable = 1'b0;
    step();
    tests_run++; if (bus.conv_done !== 1'b0 || bus.busy !== 1'b0 || bus.start !== 1'b0) begin tests_failed++; $display("FAIL basic_ack: got done %0b busy %0b start %0b want 0/0/0", bus.conv_done, bus.busy, bus.start); end
    step();
  endtask

  task automatic test_lanes();
    bus.enable = 1'b1;
    step();
    step();
    step();
    for (int r = 0; r < 16; r++) begin
      tests_run++; if (bus.count_sload !== 4'(r % 4) || bus.group !== 1'((r / 4) % 2)) begin tests_failed++; $display("FAIL lanes_cnt r=%0d: got cs %0d grp %0d want %0d/%0d", r, bus.count_sload, bus.group, r % 4, (r / 4) % 2); end
      tests_run++; if (bus.in_feature_q_a_mux_all !== exp_lanes(1'b0, (r / 4) % 2, r % 4)) begin tests_failed++; $display("FAIL lanes_a r=%0d: got %h want %h", r, bus.in_feature_q_a_mux_all, exp_lanes(1'b0, (r / 4) % 2, r % 4)); end
      tests_run++; if (bus.in_feature_q_b_mux_all !== exp_lanes(1'b1, (r / 4) % 2, r % 4)) begin tests_failed++; $display("FAIL lanes_b r=%0d: got %h want %h", r, bus.in_feature_q_b_mux_all, exp_lanes(1'b1, (r / 4) % 2, r % 4)); end
      step();
    end
    step();
    step();
    bus.enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_stall();
    int done_e;
    done_e = -1;
    bus.enable = 1'b1;
    step();
    for (int e = 1; e <= 25; e++) begin
      step();
      if (done_e < 0 && bus.conv_done === 1'b1) done_e = e;
      if (e >= 4 && e <= 7) begin
        tests_run++; if (bus.count_sload !== 4'd2) begin tests_failed++; $display("FAIL stall_hold e=%0d: got cs %0d want 2", e, bus.count_sload); end
      end
      bus.stall = (e >= 4 && e <= 6);
      #1;
      if (e >= 4 && e <= 7) begin
        tests_run++; if (bus.enable_mult !== (e == 7) || bus.enable_addrger !== (e == 7)) begin tests_failed++; $display("FAIL stall_enable e=%0d: got mult %0b addr %0b want %0b", e, bus.enable_mult, bus.enable_addrger, (e == 7)); end
      end
    end
    tests_run++; if (done_e !== 23) begin tests_failed++; $display("FAIL stall_done_edge: got %0d want 23", done_e); end
    bus.stall  = 1'b0;
    bus.enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_abort();
    int seen_done;
    int done_e;
    seen_done = 0;
    done_e = -1;
    bus.enable = 1'b1;
    step();
    for (int e = 1; e <= 12; e++) begin
      step();
      if (bus.conv_done === 1'b1) seen_done++;
      if (e == 11) begin
        tests_run++; if (bus.start !== 1'b1 || bus.count_sload !== 4'd1) begin tests_failed++; $display("FAIL abort_pre: got start %0b cs %0d want 1/1", bus.start, bus.count_sload); end
        bus.enable = 1'b0;
      end
    end
    tests_run++; if (bus.busy !== 1'b0 || bus.count_sload !== 4'd0 || bus.start !== 1'b0) begin tests_failed++; $display("FAIL abort_idle: got busy %0b cs %0d start %0b want 0/0/0", bus.busy, bus.count_sload, bus.start); end
    tests_run++; if (bus.conv_done !== 1'b0 || seen_done !== 0 || bus.in_feature_rden_a !== 1'b0) begin tests_failed++; $display("FAIL abort_no_done: got done %0b seen %0d rden %0b want 0/0/0", bus.conv_done, seen_done, bus.in_feature_rden_a); end
    bus.enable = 1'b1;
    step();
    for (int e = 1; e <= 21; e++) begin
      step();
      if (done_e < 0 && bus.conv_done === 1'b1) done_e = e;
    end
    tests_run++; if (done_e !== 20) begin tests_failed++; $display("FAIL abort_rerun_done: got %0d want 20", done_e); end
    bus.enable = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset_drain();
    int seen_done;
    seen_done = 0;
    bus.enable = 1'b1;
    step();
    for (int e = 1; e <= 18; e++) step();
    tests_run++; if (bus.busy !== 1'b1 || bus.in_feature_rden_a !== 1'b1 || bus.start !== 1'b1) begin tests_failed++; $display("FAIL drain_pre: got busy %0b rden %0b start %0b want 1/1/1", bus.busy, bus.in_feature_rden_a, bus.start); end
    reset = 1'b1;
    bus.enable = 1'b0;
    step();
    tests_run++; if (bus.busy !== 1'b0 || bus.conv_done !== 1'b0 || bus.start !== 1'b0) begin tests_failed++; $display("FAIL drain_reset_state: got busy %0b done %0b start %0b want 0/0/0", bus.busy, bus.conv_done, bus.start); end
    tests_run++; if (bus.in_feature_rden_a !== 1'b0 || bus.enable_mult !== 1'b0 || bus.count_sload !== 4'd0 || bus.clear_mult !== 1'b0) begin tests_failed++; $display("FAIL drain_reset_outs: got rden %0b mult %0b cs %0d clr %0b want 0", bus.in_feature_rden_a, bus.enable_mult, bus.count_sload, bus.clear_mult); end
    tests_run++; if (bus.in_feature_q_a_mux_all !== 32'h0011_0010) begin tests_failed++; $display("FAIL drain_reset_mux: got %h want 00110010", bus.in_feature_q_a_mux_all); end
    reset = 1'b0;
    for (int e = 0; e < 4; e++) begin
      step();
      if (bus.conv_done === 1'b1) seen_done++;
    end
    tests_run++; if (seen_done !== 0) begin tests_failed++; $display("FAIL drain_no_done: got %0d want 0", seen_done); end
  endtask

  task automatic test_back_to_back();
    int clr_n;
    int done2;
    clr_n = 0;
    done2 = -1;
    bus.enable = 1'b1;
    step();
    for (int e = 1; e <= 45; e++) begin
      step();
      if (bus.clear_mult === 1'b1) clr_n++;
      if (e >= 24 && done2 < 0 && bus.conv_done === 1'b1) done2 = e;
      if (e == 21) begin
        tests_run++; if (bus.conv_done !== 1'b1) begin tests_failed++; $display("FAIL b2b_first_done: got %0b want 1", bus.conv_done); end
        bus.enable = 1'b0;
      end
      if (e == 22) begin
        tests_run++; if (bus.conv_done !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL b2b_gap: got done %0b busy %0b want 0/0", bus.conv_done, bus.busy); end
        bus.enable = 1'b1;
      end
    end
    tests_run++; if (clr_n !== 1) begin tests_failed++; $display("FAIL b2b_clear_pulses: got %0d want 1", clr_n); end
    tests_run++; if (done2 !== 43) begin tests_failed++; $display("FAIL b2b_second_done: got %0d want 43", done2); end
    bus.enable = 1'b0;
    step();
    step();
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.stall    = 1'b0;
    bus.in_feature_q_a_all = {16'h0013, 16'h0012, 16'h0011, 16'h0010};
    bus.in_feature_q_b_all = {16'h0023, 16'h0022, 16'h0021, 16'h0020};
    test_reset();
    test_basic();
    test_lanes();
    test_stall();
    test_abort();
    test_reset_drain();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
